// File: rtl/auth_uart_rx.sv
// auth_uart_rx: 8N1 UART receiver (LSB first) with a two-flop input synchronizer and a sticky rdy flag.
// Optional stop-bit checking is enabled by defining UART_RX_FRM_CHK_EN; frm_err is tied low otherwise.
module auth_uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic       rdy,
  output logic [7:0] rx_data,
  output logic       frm_err,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [12:0] FULL_CNT = 13'(BAUD_DIV);
  localparam logic [12:0] HALF_CNT = 13'(BAUD_DIV / 2);

  state_t      state_q, state_d;
  logic        rx_meta, rx_s, rx_prev;
  logic [12:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        tick, start_edge, start_ok, sample, stop_done, stop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Expiry is the clock on which the count steps from 1 to 0, so a reload of
  // BAUD_DIV spans exactly BAUD_DIV clocks and the counter rests at 0 in IDLE.
  assign tick = (cnt == 13'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_prev && !rx_s) state_d = START;
      START:   if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:    if (tick && bit_cnt == 4'd7) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_edge = 1'b0;
    start_ok   = 1'b0;
    sample     = 1'b0;
    stop_done  = 1'b0;
    case (state_q)
      IDLE:    start_edge = rx_prev & ~rx_s;
      START:   start_ok   = tick & ~rx_s;
      DATA:    sample     = tick;
      STOP:    stop_done  = tick;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      if (start_edge)              cnt <= HALF_CNT;
      else if (start_ok || sample) cnt <= FULL_CNT;
      else if (state_q != IDLE)    cnt <= cnt - 13'd1;
      if (start_ok)    bit_cnt <= 4'd0;
      else if (sample) bit_cnt <= bit_cnt + 4'd1;
      if (sample) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

`ifdef UART_RX_FRM_CHK_EN
  assign stop_ok = stop_done & rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frm_err <= 1'b0;
    else        frm_err <= stop_done & ~rx_s;
  end
`else
  assign stop_ok = stop_done;
  assign frm_err = 1'b0;
`endif

  // rdy/clr_rdy handshake: rdy rises when a byte lands in rx_data and holds until
  // clr_rdy is sampled high or a new start edge arrives; a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy     <= 1'b0;
      rx_data <= 8'h00;
    end else if (stop_ok) begin
      rdy     <= 1'b1;
      rx_data <= shift_q;
    end else if (clr_rdy || start_edge) begin
      rdy     <= 1'b0;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_auth_uart_rx.sv
// Bench for auth_uart_rx: a fast-baud instance under a scoreboard with random frames, plus a
// full-rate (BAUD_DIV=2604) instance for the latency, acknowledge and glitch cases.
`timescale 1ns/1ps
module tb_auth_uart_rx;
  localparam int BD      = 40;
  localparam int BD_FULL = 2604;
  localparam int LAT     = 2 + BD / 2 + 9 * BD + 1;
  localparam int LAT_F   = 2 + BD_FULL / 2 + 9 * BD_FULL + 1;
`ifdef UART_RX_FRM_CHK_EN
  localparam bit FRM_CHK = 1'b1;
`else
  localparam bit FRM_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rx, clr_rdy, rdy, frm_err;
  logic [7:0] rx_data;
  logic [1:0] fsm_state;
  logic       rst_f, rx_f, clr_f, rdy_f, frm_err_f;
  logic [7:0] rx_data_f;
  logic [1:0] fsm_state_f;

  auth_uart_rx #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .clr_rdy(clr_rdy),
    .rdy(rdy), .rx_data(rx_data), .frm_err(frm_err), .fsm_state(fsm_state)
  );

  auth_uart_rx #(.BAUD_DIV(BD_FULL)) dut_full (
    .clk(clk), .rst_n(rst_f), .RX(rx_f), .clr_rdy(clr_f),
    .rdy(rdy_f), .rx_data(rx_data_f), .frm_err(frm_err_f), .fsm_state(fsm_state_f)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state and reference model
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_err  = 0;
  int         err_seen = 0;
  logic [7:0] last_data = 8'h00;
  logic       model_rdy = 1'b0;
  logic       rdy_d = 1'b0;
  logic       frm_d = 1'b0;
  logic [7:0] sb_exp;
  int         sb_start;
  bit         big_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_checks++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // monitor: pop one expected byte every time rdy rises
  always @(negedge clk) begin
    if (rst_n && rdy && !rdy_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdy: got rdy=1 rx_data=0x%0h, expected no delivery", rx_data);
      end else begin
        sb_exp   = exp_q.pop_front();
        sb_start = start_q.pop_front();
        check("sb_rx_data", rx_data, sb_exp);
        check("sb_frm_err_at_rdy", frm_err, 1'b0);
        check_range("sb_latency", cyc - sb_start, LAT - 1, LAT + 1);
      end
    end
    if (rst_n && frm_err) begin
      err_seen <= err_seen + 1;
      if (frm_d) check("frm_err_one_cycle", frm_err, 1'b0);
    end
    rdy_d <= rdy;
    frm_d <= frm_err;
  end

  // drivers (entered and left just after a rising edge)
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    if (stop_bit || !FRM_CHK) begin
      exp_q.push_back(d);
      start_q.push_back(cyc + 1);
      last_data = d;
      model_rdy = 1'b1;
    end else begin
      exp_err++;
      model_rdy = 1'b0;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    idle(1);
    clr_rdy = 1'b0;
    model_rdy = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rdy"}, rdy, model_rdy);
    check({tag, "_rx_data"}, rx_data, last_data);
    check({tag, "_frm_err_count"}, err_seen, exp_err);
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // main sequence on the fast instance
  initial begin : main_seq
    logic [7:0] d;
    logic       sb;
    int         gap;
    rx = 1'b1; clr_rdy = 1'b0; rst_n = 1'b0;
    rx_f = 1'b1; clr_f = 1'b0; rst_f = 1'b0;
    idle(3);
    check("reset_rdy", rdy, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_state", fsm_state, 2'd0);
    check("reset_full_rx_data", rx_data_f, 8'h00);
    rst_n = 1'b1; rst_f = 1'b1;
    idle(5);

    send_frame(8'h47, 1'b1);
    idle(2);
    check_state("byte_47");

    pulse_clr();
    check("clr_rdy_next_clk", rdy, 1'b0);
    check("clr_keeps_data", rx_data, 8'h47);

    rx = 1'b0;
    idle(5);
    check("glitch_seen_as_start", fsm_state, 2'd1);
    idle(5);
    rx = 1'b1;
    idle(30);
    check("glitch_back_to_idle", fsm_state, 2'd0);
    check_state("glitch");

    send_frame(8'h53, 1'b0);
    idle(4);
    check_state("bad_stop");
    if (rdy) pulse_clr();

    send_frame(8'h47, 1'b1);
    check("b2b_first_rdy", rdy, 1'b1);
    fork
      send_frame(8'h53, 1'b1);
      begin
        idle(2);
        check("b2b_rdy_before_edge", rdy, 1'b1);
        idle(1);
        check("b2b_rdy_drops_at_start", rdy, 1'b0);
      end
    join
    idle(2);
    check_state("b2b_second");

    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    idle(BD / 2);
    rst_n = 1'b0;
    idle(2);
    check("midreset_rdy", rdy, 1'b0);
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_state", fsm_state, 2'd0);
    last_data = 8'h00;
    model_rdy = 1'b0;
    rst_n = 1'b1;
    rx = 1'b1;
    idle(6 * BD);
    check_state("after_reset_idle");
    send_frame(8'h47, 1'b1);
    idle(2);
    check_state("after_reset_frame");

    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, BD);
      if (!sb && gap < 2) gap = 2;
      send_frame(d, sb);
      check_state("rand_frame");
      if ($urandom_range(0, 1) == 1) pulse_clr();
      if (gap > 0) idle(gap);
    end
    idle(2 * BD);

    for (int c = 0; c < 40000 && !big_done; c++) idle(1);
    check("full_rate_done", big_done, 1'b1);
    check("scoreboard_drained", exp_q.size(), 0);
    check("frm_err_total", err_seen, exp_err);
    report();
    $finish;
  end

  // full-rate instance: latency, acknowledge and line glitch
  initial begin : full_rate
    logic [9:0] fr;
    int         t0, lat, back;
    bit         seen;
    wait (rst_f == 1'b1);
    idle(5);
    fr   = {1'b1, 8'h47, 1'b0};
    t0   = cyc + 1;
    seen = 1'b0;
    lat  = 0;
    fork
      for (int i = 0; i < 10; i++) begin
        rx_f = fr[i];
        repeat (BD_FULL) @(posedge clk);
        #1;
      end
      for (int c = 0; c < 11 * BD_FULL && !seen; c++) begin
        @(negedge clk);
        if (rdy_f) begin
          seen = 1'b1;
          lat  = cyc - t0;
        end
      end
    join
    rx_f = 1'b1;
    check("full_rdy_seen", seen, 1'b1);
    check_range("full_latency", lat, LAT_F - 1, LAT_F + 1);
    check("full_rx_data", rx_data_f, 8'h47);
    check("full_frm_err", frm_err_f, 1'b0);

    clr_f = 1'b1;
    idle(1);
    clr_f = 1'b0;
    check("full_clr_rdy", rdy_f, 1'b0);
    check("full_clr_keeps_data", rx_data_f, 8'h47);

    rx_f = 1'b0;
    idle(500);
    rx_f = 1'b1;
    check("full_glitch_in_start", fsm_state_f, 2'd1);
    back = -1;
    for (int c = 0; c < 1500 && back < 0; c++) begin
      idle(1);
      if (fsm_state_f == 2'd0) back = c;
    end
    check("full_glitch_idle_by_2000", back >= 0, 1'b1);
    check("full_glitch_no_rdy", rdy_f, 1'b0);
    check("full_glitch_data", rx_data_f, 8'h47);
    big_done = 1'b1;
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
    report();
    $finish;
  end

endmodule
